ptw_walk_ctrl: RTL
==================

// Module: ptw_walk_ctrl
// PURPOSE
//  Sv39 page-table-walk sequencer. Accepts an L2-TLB miss (VPN) and fetches PTEs level by level (L3->L2->L1).
//  It drives the combinational PTE checker with level/PPN/ctrl and consumes its done/exception verdict.
//  It returns the leaf PPN/ctrl/level, or an exception, to the L2-TLB. One walk at a time; no PTE cache.
// PARAMETERS
//  VPN_LEN     27   virtual page number width (3 x 9-bit slices)
//  PPN_LEN     44   physical page number width (p2:26, p1:9, p0:9)
//  PADDR_LEN   56   physical address width of PTE fetches
//  TIMEOUT_CYC 256  max cycles waiting for a memory answer; 0 disables the timeout
// PORTS
//  clk_i            in   1        clock
//  rst_i            in   1        synchronous reset, active-high
//  flush_i          in   1        abort current walk (sfence.vma / satp write)
//  satp_ppn_i       in   PPN_LEN  page-table root PPN, sampled at request accept
//  req_valid_i      in   1        miss request valid
//  req_ready_o      out  1        ready for a new walk
//  req_vpn_i        in   VPN_LEN  VPN to translate
//  mem_req_valid_o  out  1        PTE fetch request valid
//  mem_req_ready_i  in   1        memory accepts request
//  mem_req_addr_o   out  PADDR_LEN PTE address, 8-byte aligned
//  mem_ans_valid_i  in   1        PTE answer valid (always accepted)
//  mem_ans_data_i   in   64       raw PTE
//  mem_ans_err_i    in   1        bus error on the fetch
//  chk_en_o         out  1        checker enable
//  chk_level_o      out  pte_level_e level of the checked item (Root/L3/L2/L1)
//  chk_ppn_o        out  ppn_t    PPN under check
//  chk_ctrl_o       out  pte_ctrl_t PTE control bits under check
//  chk_exception_i  in   exception_e checker verdict
//  chk_done_i       in   1        checker: stop walk
//  ans_valid_o      out  1        walk result valid
//  ans_ready_i      in   1        L2-TLB accepts result
//  ans_ppn_o        out  ppn_t    leaf PPN
//  ans_ctrl_o       out  pte_ctrl_t leaf control bits
//  ans_level_o      out  pte_level_e leaf level (L3 = 1 GiB page, L2 = 2 MiB page, L1 = 4 KiB page)
//  ans_exception_o  out  exception_e NoException, PageFault or AccessFault
// BEHAVIOUR
//  FSM states: IDLE, CHECK, MEM_REQ, MEM_WAIT, RESP, DRAIN.
//  Reset: state IDLE. Outputs: req_ready_o=1, all valids=0, chk_en_o=0, addr/ppn/ctrl=0, level=Root,
//   ans_exception_o=NoException, timeout counter=0.
//  IDLE: req_ready_o=1. On req_valid_i, latch the VPN and set ppn_q=satp_ppn_i, level_q=Root, ctrl_q=0.
//   Go to CHECK.
//  CHECK: chk_en_o=1, with checker inputs taken from level_q/ppn_q/ctrl_q (registered; one cycle in this state).
//   chk_done_i=0: go to MEM_REQ. Next level: Root->L3, L3->L2, L2->L1.
//   chk_done_i=1: latch the verdict into the ans_* registers and go to RESP.
//  MEM_REQ: mem_req_valid_o=1.
//   mem_req_addr_o = {ppn_q,12'b0} + {vpn_slice,3'b0}, truncated or zero-extended to PADDR_LEN.
//   vpn_slice is VPN[26:18] for L3, VPN[17:9] for L2, VPN[8:0] for L1.
//   Address must stay stable until mem_req_ready_i. On handshake go to MEM_WAIT and clear the timeout counter.
//  MEM_WAIT: on mem_ans_valid_i && !mem_ans_err_i, set ctrl_q=data[7:0], ppn_q=data[53:10]; go to CHECK.
//   On mem_ans_err_i: AccessFault -> RESP.
//   When the counter reaches TIMEOUT_CYC-1 with no answer (TIMEOUT_CYC!=0): AccessFault -> RESP.
//  RESP: ans_valid_o=1 and ans_* stable until ans_ready_i. On handshake return to IDLE.
//   req_ready_o is 0 in every state except IDLE.
//  Answer fields: on PageFault or AccessFault, ans_ppn_o/ans_ctrl_o are 0 and ans_level_o is the failing level.
//  Latency without stalls:
//   accept -> CHECK(Root) -> 3 x (MEM_REQ + MEM_WAIT(n) + CHECK) -> RESP, for an L1 leaf with 1-cycle memory.
//  flush_i has priority over every other event in the same cycle:
//   From CHECK, MEM_REQ, RESP or IDLE: go to IDLE and drop the result (no ans_valid_o).
//   From MEM_WAIT (answer outstanding): go to DRAIN. DRAIN keeps req_ready_o=0.
//    The next mem_ans_valid_i (any err) is discarded, then go to IDLE.
//    A timeout in DRAIN also goes to IDLE.
//   A flush in the same cycle as mem_ans_valid_i in MEM_WAIT goes straight to IDLE (answer consumed).
//  A flush in the cycle of the ans handshake: the handshake completes; next state is IDLE.
//  mem_ans_valid_i outside MEM_WAIT/DRAIN is ignored.
//  Timeout counter saturates; width is $clog2(TIMEOUT_CYC+1).
// TESTING
//  satp=0x80, VPN=0x0_0000_01, three valid non-leaf/leaf PTEs with L1 leaf ppn=0x1234, RWXA=1
//   -> addrs 0x80000, then next tables; ans ppn=0x1234, level=L1, NoException.
//  L3 PTE leaf with ppn=0x40000 (p1=p0=0), A=1 -> exactly one fetch; ans level=L3, NoException.
//   Same PTE with ppn p0=0x1 -> PageFault.
//  L2 PTE with V=0 -> PageFault, level=L2; L1 non-leaf pointer -> PageFault, level=L1.
//  mem_ans_err_i=1 on the second fetch -> AccessFault.
//   TIMEOUT_CYC=4 with no answer -> AccessFault exactly 4 cycles after the request handshake.
//  flush_i while in MEM_WAIT, answer arrives 3 cycles later -> no ans_valid_o; req_ready_o=1 the cycle after the answer.
//   A new walk then completes normally.
//  mem_req_ready_i held low 5 cycles and ans_ready_i held low 3 cycles
//   -> addr/ans fields stable throughout; exactly one result per request.

Source files
------------

// File: rtl/ptw_walk_ctrl.sv
// Sv39 page-table-walk sequencer: fetches PTEs L3->L2->L1, feeds the external PTE checker
// and returns the leaf translation or a fault to the L2-TLB. One walk in flight.
module ptw_walk_ctrl #(
  parameter int unsigned VPN_LEN     = 27,
  parameter int unsigned PPN_LEN     = 44,
  parameter int unsigned PADDR_LEN   = 56,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [PPN_LEN-1:0]   satp_ppn_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [VPN_LEN-1:0]   req_vpn_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [PADDR_LEN-1:0] mem_req_addr_o,
  input  logic                 mem_ans_valid_i,
  input  logic [63:0]          mem_ans_data_i,
  input  logic                 mem_ans_err_i,
  output logic                 chk_en_o,
  output logic [1:0]           chk_level_o,
  output logic [PPN_LEN-1:0]   chk_ppn_o,
  output logic [7:0]           chk_ctrl_o,
  input  logic [1:0]           chk_exception_i,
  input  logic                 chk_done_i,
  output logic                 ans_valid_o,
  input  logic                 ans_ready_i,
  output logic [PPN_LEN-1:0]   ans_ppn_o,
  output logic [7:0]           ans_ctrl_o,
  output logic [1:0]           ans_level_o,
  output logic [1:0]           ans_exception_o
);

  localparam logic [1:0] LVL_ROOT   = 2'd0;
  localparam logic [1:0] LVL_L3     = 2'd1;
  localparam logic [1:0] LVL_L2     = 2'd2;
  localparam logic [1:0] LVL_L1     = 2'd3;
  localparam logic [1:0] EXC_NONE   = 2'd0;
  localparam logic [1:0] EXC_ACCESS = 2'd2;

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned AW    = PPN_LEN + 12;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MEM_REQ, S_MEM_WAIT, S_RESP, S_DRAIN
  } state_e;

  state_e             state_q;
  logic [VPN_LEN-1:0] vpn_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [1:0]    next_level_c;
  logic [8:0]    slice_c;
  logic [AW-1:0] pte_addr_c;
  logic          timeout_c;
  logic          cnt_sat_c;
  logic          unused_data_c;

  // Address of the next-level PTE, computed from the table PPN currently held for the checker
  assign next_level_c = (chk_level_o == LVL_L1) ? LVL_L1 : chk_level_o + 2'd1;

  always_comb begin
    slice_c = vpn_q[8:0];
    case (next_level_c)
      LVL_L3:  slice_c = vpn_q[26:18];
      LVL_L2:  slice_c = vpn_q[17:9];
      default: slice_c = vpn_q[8:0];
    endcase
  end

  assign pte_addr_c    = {chk_ppn_o, 12'h000} + AW'({slice_c, 3'b000});
  assign timeout_c     = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign cnt_sat_c     = (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign unused_data_c = ^{mem_ans_data_i[63:54], mem_ans_data_i[9:8]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      req_ready_o     <= 1'b1;
      mem_req_valid_o <= 1'b0;
      chk_en_o        <= 1'b0;
      ans_valid_o     <= 1'b0;
      mem_req_addr_o  <= '0;
      vpn_q           <= '0;
      cnt_q           <= '0;
      chk_level_o     <= LVL_ROOT;
      chk_ppn_o       <= '0;
      chk_ctrl_o      <= '0;
      ans_ppn_o       <= '0;
      ans_ctrl_o      <= '0;
      ans_level_o     <= LVL_ROOT;
      ans_exception_o <= EXC_NONE;
    end else begin
      req_ready_o     <= 1'b0;
      mem_req_valid_o <= 1'b0;
      chk_en_o        <= 1'b0;
      ans_valid_o     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            req_ready_o <= 1'b1;
          end else if (req_valid_i) begin
            state_q     <= S_CHECK;
            chk_en_o    <= 1'b1;
            vpn_q       <= req_vpn_i;
            chk_ppn_o   <= satp_ppn_i;
            chk_level_o <= LVL_ROOT;
            chk_ctrl_o  <= '0;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        S_CHECK: begin
          if (flush_i) begin
            state_q     <= S_IDLE;
            req_ready_o <= 1'b1;
          end else if (chk_done_i) begin
            state_q         <= S_RESP;
            ans_valid_o     <= 1'b1;
            ans_level_o     <= chk_level_o;
            ans_exception_o <= chk_exception_i;
            ans_ppn_o       <= (chk_exception_i == EXC_NONE) ? chk_ppn_o : '0;
            ans_ctrl_o      <= (chk_exception_i == EXC_NONE) ? chk_ctrl_o : '0;
          end else begin
            state_q         <= S_MEM_REQ;
            mem_req_valid_o <= 1'b1;
            chk_level_o     <= next_level_c;
            mem_req_addr_o  <= PADDR_LEN'(pte_addr_c);
          end
        end
        S_MEM_REQ: begin
          if (flush_i) begin
            state_q     <= S_IDLE;
            req_ready_o <= 1'b1;
          end else if (mem_req_ready_i) begin
            state_q <= S_MEM_WAIT;
            cnt_q   <= '0;
          end else begin
            mem_req_valid_o <= 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (flush_i) begin
            // An answer in the flush cycle is consumed; otherwise it is still owed and must be drained
            if (mem_ans_valid_i) begin
              state_q     <= S_IDLE;
              req_ready_o <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
              if (!cnt_sat_c) cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (mem_ans_valid_i && !mem_ans_err_i) begin
            state_q    <= S_CHECK;
            chk_en_o   <= 1'b1;
            chk_ctrl_o <= mem_ans_data_i[7:0];
            chk_ppn_o  <= mem_ans_data_i[10 +: PPN_LEN];
          end else if (mem_ans_valid_i || timeout_c) begin
            state_q         <= S_RESP;
            ans_valid_o     <= 1'b1;
            ans_level_o     <= chk_level_o;
            ans_exception_o <= EXC_ACCESS;
            ans_ppn_o       <= '0;
            ans_ctrl_o      <= '0;
          end else if (!cnt_sat_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (mem_ans_valid_i || timeout_c) begin
            state_q     <= S_IDLE;
            req_ready_o <= 1'b1;
          end else if (!cnt_sat_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (flush_i || ans_ready_i) begin
            state_q     <= S_IDLE;
            req_ready_o <= 1'b1;
          end else begin
            ans_valid_o <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
